// File: rtl/icache_ctrl.sv
// Direct-mapped, read-only instruction cache with a line-refill FSM.
// A miss holds o_miss high while a full line is fetched from memory one beat per word.
module icache_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINES  = 16,
  parameter int WORDS  = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  output logic [DATA_W-1:0] o_instr,
  output logic              o_miss,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_valid,
  input  logic [DATA_W-1:0] i_mem_data
);
  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int LO_W  = OFF_W + 2;
  localparam int TAG_W = ADDR_W - IDX_W - LO_W;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t            state_q, state_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [OFF_W-1:0]  beat_q, beat_d;
  logic              drop_q, drop_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic [TAG_W-1:0]  tag_arr  [LINES];
  logic [DATA_W-1:0] data_arr [LINES][WORDS];

  logic [OFF_W-1:0]  req_word;
  logic [IDX_W-1:0]  req_idx, fill_idx;
  logic [TAG_W-1:0]  req_tag, fill_tag;
  logic              hit, data_we, tag_we;
  logic              unused_addr_bits;

  assign req_word         = i_addr[LO_W-1:2];
  assign req_idx          = i_addr[LO_W +: IDX_W];
  assign req_tag          = i_addr[ADDR_W-1 -: TAG_W];
  assign fill_idx         = mem_addr_q[LO_W +: IDX_W];
  assign fill_tag         = mem_addr_q[ADDR_W-1 -: TAG_W];
  assign unused_addr_bits = ^i_addr[1:0];

  assign hit        = i_req & valid_q[req_idx] & (tag_arr[req_idx] == req_tag);
  assign o_miss     = i_req & ~((state_q == IDLE) & hit);
  assign o_instr    = data_arr[req_idx][req_word];
  assign o_mem_req  = mem_req_q;
  assign o_mem_addr = mem_addr_q;

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    beat_d     = beat_q;
    drop_d     = drop_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    data_we    = 1'b0;
    tag_we     = 1'b0;
    if (i_flush) valid_d = '0;
    case (state_q)
      IDLE: begin
        if (i_req && !hit) begin
          state_d    = REFILL;
          mem_req_d  = 1'b1;
          beat_d     = '0;
          mem_addr_d = {i_addr[ADDR_W-1:LO_W], {LO_W{1'b0}}};
        end
      end
      REFILL: begin
        // A flush during refill poisons the line being filled, even on its last beat.
        if (i_flush) drop_d = 1'b1;
        if (i_mem_valid) begin
          data_we = 1'b1;
          beat_d  = beat_q + OFF_W'(1);
          if (beat_q == OFF_W'(WORDS - 1)) begin
            tag_we            = 1'b1;
            valid_d[fill_idx] = ~(drop_q | i_flush);
            drop_d            = 1'b0;
            mem_req_d         = 1'b0;
            state_d           = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      beat_q     <= '0;
      drop_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      beat_q     <= beat_d;
      drop_q     <= drop_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // Storage arrays carry no reset; the valid bits alone decide what may hit.
  always_ff @(posedge Clk) begin
    if (!Rst && data_we) data_arr[fill_idx][beat_q] <= i_mem_data;
    if (!Rst && tag_we)  tag_arr[fill_idx] <= fill_tag;
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Scoreboard bench for icache_ctrl: a driver issues fetches and plays memory beats,
// a monitor pops expected instructions whenever the cache serves a request.
module tb_icache_ctrl;
  logic        Clk = 1'b0;
  logic        Rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_flush;
  logic [31:0] o_instr;
  logic        o_miss;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_valid;
  logic [31:0] i_mem_data;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q [$];
  logic [31:0] mem_img [logic [31:0]];
  bit          m_valid [16];
  logic [31:0] m_tag [16];
  logic [31:0] m_data [16][4];
  logic [31:0] tag_pool [4];

  icache_ctrl #(.ADDR_W(32), .DATA_W(32), .LINES(16), .WORDS(4)) dut (
    .Clk(Clk), .Rst(Rst), .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
    .o_instr(o_instr), .o_miss(o_miss), .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
    .i_mem_valid(i_mem_valid), .i_mem_data(i_mem_data)
  );

  always #5 Clk = ~Clk;

  // Main memory image: explicit entries for directed tests, a hash everywhere else.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 32'd16) % 32'd16);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a / 32'd4) % 32'd4);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a / 32'd256;
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a - (a % 32'd16);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
  endfunction

  task automatic model_flush();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  task automatic model_fill(input logic [31:0] a);
    m_tag[idx_of(a)] = tag_of(a);
    for (int w = 0; w < 4; w++) m_data[idx_of(a)][w] = mem_word(line_of(a) + 32'(4 * w));
    m_valid[idx_of(a)] = 1'b1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // One fetch: present the request, service any refill (with optional flushes), until served.
  task automatic applyStimulus(input logic [31:0] addr, input int gap_lo, input int gap_hi,
                               input int flush_beat, input bit flush_on_req);
    bit          exp_hit;
    bit          flushed;
    int          gap;
    logic [31:0] line;
    line    = line_of(addr);
    exp_hit = model_hit(addr);
    @(posedge Clk); #1;
    if (exp_hit) exp_q.push_back(m_data[idx_of(addr)][word_of(addr)]);
    else         exp_q.push_back(mem_word(line + 32'(4 * word_of(addr))));
    i_req = 1'b1; i_addr = addr; i_flush = flush_on_req; i_mem_valid = 1'b0;
    @(negedge Clk);
    checkOutput("miss_on_request", 32'(o_miss), 32'(!exp_hit));
    if (flush_on_req) model_flush();
    if (exp_hit) return;
    for (int attempt = 0; attempt < 2; attempt++) begin
      flushed = 1'b0;
      for (int b = 0; b < 4; b++) begin
        gap = int'($urandom_range(gap_hi, gap_lo));
        for (int g = 0; g < gap; g++) begin
          @(posedge Clk); #1;
          i_flush = 1'b0; i_mem_valid = 1'b0; i_mem_data = $urandom(); i_addr = $urandom();
          @(negedge Clk);
          checkOutput("miss_in_gap", 32'(o_miss), 32'd1);
          checkOutput("mem_req_in_gap", 32'(o_mem_req), 32'd1);
        end
        @(posedge Clk); #1;
        i_mem_valid = 1'b1; i_mem_data = mem_word(line + 32'(4 * b)); i_addr = $urandom();
        i_flush = (attempt == 0) && (b == flush_beat);
        if (i_flush) flushed = 1'b1;
        @(negedge Clk);
        checkOutput("mem_req_beat", 32'(o_mem_req), 32'd1);
        checkOutput("mem_addr_beat", o_mem_addr, line);
        checkOutput("miss_beat", 32'(o_miss), 32'd1);
      end
      @(posedge Clk); #1;
      i_mem_valid = 1'b0; i_flush = 1'b0; i_addr = addr; i_mem_data = $urandom();
      if (flushed) model_flush();
      else         model_fill(addr);
      @(negedge Clk);
      checkOutput("mem_req_after_fill", 32'(o_mem_req), 32'd0);
      checkOutput("miss_after_fill", 32'(o_miss), 32'(flushed));
      if (!flushed) break;
    end
  endtask

  task automatic idleCycle(input bit flush);
    @(posedge Clk); #1;
    i_req = 1'b0; i_flush = flush; i_mem_valid = 1'b0; i_addr = $urandom(); i_mem_data = $urandom();
    @(negedge Clk);
    checkOutput("idle_no_miss", 32'(o_miss), 32'd0);
    checkOutput("idle_no_mem_req", 32'(o_mem_req), 32'd0);
    if (flush) model_flush();
  endtask

  // Start a refill, hit it with reset after two beats, then throw stray beats at it.
  task automatic resetMidRefill(input logic [31:0] addr);
    logic [31:0] line;
    bit          exp_hit;
    line    = line_of(addr);
    exp_hit = model_hit(addr);
    @(posedge Clk); #1;
    i_req = 1'b1; i_addr = addr; i_flush = 1'b0; i_mem_valid = 1'b0;
    @(negedge Clk);
    checkOutput("rst_case_miss", 32'(o_miss), 32'(!exp_hit));
    for (int b = 0; b < 2; b++) begin
      @(posedge Clk); #1;
      i_mem_valid = 1'b1; i_mem_data = mem_word(line + 32'(4 * b));
      @(negedge Clk);
      checkOutput("rst_case_mem_req", 32'(o_mem_req), 32'd1);
    end
    @(posedge Clk); #1;
    Rst = 1'b1; i_req = 1'b0; i_mem_valid = 1'b0;
    @(posedge Clk); #1;
    Rst = 1'b0; i_mem_valid = 1'b1; i_mem_data = $urandom();
    model_flush();
    @(negedge Clk);
    checkOutput("rst_mid_mem_req", 32'(o_mem_req), 32'd0);
    checkOutput("rst_mid_mem_addr", o_mem_addr, 32'd0);
    checkOutput("rst_mid_miss", 32'(o_miss), 32'd0);
    for (int s = 0; s < 3; s++) begin
      @(posedge Clk); #1;
      i_mem_valid = 1'b1; i_mem_data = $urandom();
      @(negedge Clk);
      checkOutput("stray_beat_mem_req", 32'(o_mem_req), 32'd0);
    end
  endtask

  // Monitor: whenever the cache serves a fetch, the oldest expectation must match it.
  initial begin
    logic [31:0] exp;
    forever begin
      @(negedge Clk);
      if (!Rst && i_req && !o_miss) begin
        checkOutput("output_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp = exp_q.pop_front();
          checkOutput("instr", o_instr, exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          r;
    int          fb;
    logic [31:0] a;
    Rst = 1'b1; i_req = 1'b0; i_addr = '0; i_flush = 1'b0; i_mem_valid = 1'b0; i_mem_data = '0;
    model_flush();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    checkOutput("reset_mem_req", 32'(o_mem_req), 32'd0);
    checkOutput("reset_mem_addr", o_mem_addr, 32'd0);
    checkOutput("reset_miss", 32'(o_miss), 32'd0);
    @(posedge Clk); #1;
    Rst = 1'b0;
    repeat (3) idleCycle(1'b0);

    for (int w = 0; w < 4; w++) begin
      mem_img[32'h100 + 32'(4 * w)] = 32'hA0 + 32'(w);
      mem_img[32'h200 + 32'(4 * w)] = 32'hB0 + 32'(w);
    end
    applyStimulus(32'h100, 0, 0, -1, 1'b0);
    applyStimulus(32'h104, 0, 0, -1, 1'b0);
    applyStimulus(32'h10C, 0, 0, -1, 1'b0);
    applyStimulus(32'h200, 0, 0, -1, 1'b0);
    applyStimulus(32'h100, 0, 0, -1, 1'b0);
    applyStimulus(32'h300, 2, 2, -1, 1'b0);
    for (int w = 0; w < 4; w++) applyStimulus(32'h300 + 32'(4 * w), 0, 0, -1, 1'b0);
    applyStimulus(32'h200, 0, 0, -1, 1'b0);
    applyStimulus(32'h100, 0, 0, 2, 1'b0);
    applyStimulus(32'h104, 0, 0, -1, 1'b0);
    applyStimulus(32'h308, 0, 1, -1, 1'b0);
    resetMidRefill(32'h500);
    applyStimulus(32'h100, 0, 0, -1, 1'b0);
    applyStimulus(32'h200, 0, 1, 3, 1'b0);
    applyStimulus(32'h20C, 0, 0, -1, 1'b1);
    applyStimulus(32'h104, 0, 0, -1, 1'b0);
    idleCycle(1'b1);
    applyStimulus(32'h208, 0, 0, -1, 1'b0);

    for (int i = 0; i < 4; i++) tag_pool[i] = $urandom() & 32'h00FFFFFF;
    for (int n = 0; n < 150; n++) begin
      r = int'($urandom_range(99, 0));
      if (r < 10) begin
        idleCycle(r < 4);
      end else begin
        a = tag_pool[$urandom_range(3, 0)] * 32'd256 + 32'($urandom_range(3, 0)) * 32'd16
            + 32'($urandom_range(3, 0)) * 32'd4;
        fb = -1;
        if ($urandom_range(5, 0) == 0) fb = int'($urandom_range(3, 0));
        applyStimulus(a, 0, 2, fb, $urandom_range(9, 0) == 0);
      end
    end
    idleCycle(1'b0);
    @(negedge Clk);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
